ic_source_queue: RTL and testbench

// - Per-node flit buffer that feeds one input lane of the interconnect source partition.
// - Accepts flits with their nexthop address from a router or FQ/TG output.
// - Presents the head flit show-ahead as src_data_in/src_nexthop_in/src_data_valid(_urgent).
// - Pops the head when the partition asserts that lane's src_dequeue bit.
// - Raises urgent when the queue is nearly full or the head has waited too long.
//

---
 rtl/ic_source_queue.sv | 103 ++++++++++
 tb/tb_ic_source_queue.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ic_source_queue.sv
// Per-node flit queue feeding one source-partition input lane; show-ahead head with urgency flag.
// Optional occupancy statistics are built when IC_SRCQ_STATS_EN is defined.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

module ic_source_queue #(
  parameter int WIDTH         = `FLIT_WIDTH,
  parameter int LOG_DEPTH     = 3,
  parameter int URGENT_THRESH = 6,
  parameter int AGE_WIDTH     = 4,
  parameter int MAX_WAIT      = 15
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [`ADDR_WIDTH-1:0] in_nexthop,
  output logic                   in_ready,
  input  logic                   dequeue,
  output logic                   out_valid,
  output logic                   out_valid_urgent,
  output logic [WIDTH-1:0]       out_data,
  output logic [`ADDR_WIDTH-1:0] out_nexthop,
`ifdef IC_SRCQ_STATS_EN
  output logic [15:0]            stat_overflow,
  output logic [LOG_DEPTH:0]     stat_max_occ,
`endif
  output logic [LOG_DEPTH:0]     count
);

  localparam int DEPTH = 2 ** LOG_DEPTH;
  localparam logic [LOG_DEPTH:0]   FULL_CNT   = (LOG_DEPTH + 1)'(DEPTH);
  localparam logic [LOG_DEPTH:0]   URGENT_CNT = (LOG_DEPTH + 1)'(URGENT_THRESH);
  localparam logic [AGE_WIDTH-1:0] MAX_AGE    = AGE_WIDTH'(MAX_WAIT);

  logic [WIDTH-1:0]       mem_data [DEPTH];
  logic [`ADDR_WIDTH-1:0] mem_hop  [DEPTH];
  logic [LOG_DEPTH-1:0]   wr_ptr;
  logic [LOG_DEPTH-1:0]   rd_ptr;
  logic [AGE_WIDTH-1:0]   age;
  logic [LOG_DEPTH:0]     count_nxt;
  logic                   push;
  logic                   pop;

  assign in_ready         = (count != FULL_CNT);
  assign out_valid        = (count != '0);
  assign out_data         = mem_data[rd_ptr];
  assign out_nexthop      = mem_hop[rd_ptr];
  assign out_valid_urgent = out_valid & ((count >= URGENT_CNT) | (age == MAX_AGE));

  assign push = in_valid & in_ready & enable;
  assign pop  = dequeue & out_valid & enable;

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (pop && !push) count_nxt = count - 1'b1;
  end

  // Payload storage carries no reset; only valid entries are ever presented.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_data[wr_ptr] <= in_data;
      mem_hop[wr_ptr]  <= in_nexthop;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      age    <= '0;
    end else if (enable) begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      // Age belongs to the current head: any pop hands a fresh head a zero age.
      if (pop || !out_valid)  age <= '0;
      else if (age != MAX_AGE) age <= age + 1'b1;
    end
  end

`ifdef IC_SRCQ_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_overflow <= '0;
      stat_max_occ  <= '0;
    end else if (enable) begin
      if (in_valid && !in_ready && stat_overflow != 16'hFFFF)
        stat_overflow <= stat_overflow + 16'd1;
      if (count_nxt > stat_max_occ)
        stat_max_occ <= count_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_ic_source_queue.sv
// Directed bench for ic_source_queue: ordering, full/overflow, simultaneous push/pop,
// head-age urgency with enable stalls, reset flush and pointer wrap.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

module tb_ic_source_queue;

  localparam int W  = `FLIT_WIDTH;
  localparam int AW = `ADDR_WIDTH;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic [AW-1:0] in_nexthop;
  logic          in_ready;
  logic          dequeue;
  logic          out_valid;
  logic          out_valid_urgent;
  logic [W-1:0]  out_data;
  logic [AW-1:0] out_nexthop;
  logic [3:0]    count;
`ifdef IC_SRCQ_STATS_EN
  logic [15:0]   stat_overflow;
  logic [3:0]    stat_max_occ;
`endif

  int checks   = 0;
  int failures = 0;

  ic_source_queue dut (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_nexthop       (in_nexthop),
    .in_ready         (in_ready),
    .dequeue          (dequeue),
    .out_valid        (out_valid),
    .out_valid_urgent (out_valid_urgent),
    .out_data         (out_data),
    .out_nexthop      (out_nexthop),
`ifdef IC_SRCQ_STATS_EN
    .stat_overflow    (stat_overflow),
    .stat_max_occ     (stat_max_occ),
`endif
    .count            (count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; in_data = '0;
    in_nexthop = '0; dequeue = 1'b0;
    tick(); tick();
    reset = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_urgent",    64'(out_valid_urgent), 64'd0);
    check("rst_in_ready",  64'(in_ready), 64'd1);
    check("rst_count",     64'(count), 64'd0);

    // A, B, C then three pops
    in_valid = 1'b1; in_data = 32'hA; in_nexthop = 8'h1A;
    tick();
    check("first_out_valid", 64'(out_valid), 64'd1);
    check("first_out_data",  64'(out_data), 64'hA);
    check("first_nexthop",   64'(out_nexthop), 64'h1A);
    in_data = 32'hB; in_nexthop = 8'h1B; tick();
    in_data = 32'hC; in_nexthop = 8'h1C; tick();
    in_valid = 1'b0;
    check("abc_count", 64'(count), 64'd3);
    dequeue = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("abc_pop_data", 64'(out_data), 64'(32'hA + i));
      tick();
    end
    dequeue = 1'b0;
    check("abc_count_end", 64'(count), 64'd0);
    check("abc_valid_end", 64'(out_valid), 64'd0);

    // dequeue while empty is ignored
    dequeue = 1'b1; tick(); dequeue = 1'b0;
    check("empty_deq_count", 64'(count), 64'd0);
    check("empty_deq_ready", 64'(in_ready), 64'd1);

    // fill to 8, urgent from count 6
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 32'h100 + i; in_nexthop = 8'(i);
      tick();
      check("fill_count",  64'(count), 64'(i + 1));
      check("fill_urgent", 64'(out_valid_urgent), 64'((i + 1) >= 6));
    end
    check("full_in_ready", 64'(in_ready), 64'd0);
    in_data = 32'hBAD; tick();
    check("ovf_count", 64'(count), 64'd8);
    check("ovf_head",  64'(out_data), 64'h100);
`ifdef IC_SRCQ_STATS_EN
    check("stat_overflow", 64'(stat_overflow), 64'd1);
    check("stat_max_occ",  64'(stat_max_occ), 64'd8);
`endif

    // full + push + pop: pop only
    in_data = 32'hDEAD; dequeue = 1'b1; tick();
    dequeue = 1'b0;
    check("fullpp_count", 64'(count), 64'd7);
    check("fullpp_head",  64'(out_data), 64'h101);
    check("fullpp_ready", 64'(in_ready), 64'd1);
    in_data = 32'h200; tick();
    in_valid = 1'b0;
    check("refill_count", 64'(count), 64'd8);
    dequeue = 1'b1;
    for (int i = 1; i < 9; i++) begin
      check("drain_data", 64'(out_data), (i < 8) ? 64'(32'h100 + i) : 64'h200);
      tick();
    end
    dequeue = 1'b0;
    check("drain_count", 64'(count), 64'd0);

    // head age: urgent exactly 15 enabled cycles after push
    in_valid = 1'b1; in_data = 32'h55; tick(); in_valid = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check("age_urgent", 64'(out_valid_urgent), 64'(k >= 15));
    end
    dequeue = 1'b1; tick(); dequeue = 1'b0;
    check("age_pop_valid", 64'(out_valid), 64'd0);

    // same with a 5-cycle enable stall
    in_valid = 1'b1; in_data = 32'h66; tick(); in_valid = 1'b0;
    repeat (5) tick();
    enable = 1'b0;
    in_valid = 1'b1; in_data = 32'h77;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_urgent", 64'(out_valid_urgent), 64'd0);
    end
    check("stall_count", 64'(count), 64'd1);
    in_valid = 1'b0; enable = 1'b1;
    repeat (9) tick();
    check("stall_urgent_14", 64'(out_valid_urgent), 64'd0);
    tick();
    check("stall_urgent_15", 64'(out_valid_urgent), 64'd1);
    dequeue = 1'b1; tick(); dequeue = 1'b0;
    check("stall_pop_count", 64'(count), 64'd0);

    // fill to 4 then reset flushes
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin in_data = 32'h400 + i; tick(); end
    in_valid = 1'b0;
    check("pre_rst_count", 64'(count), 64'd4);
    reset = 1'b1; tick(); reset = 1'b0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ready", 64'(in_ready), 64'd1);

    // wrap: one entry resident, 20 simultaneous push/pop pairs
    in_valid = 1'b1; in_data = 32'h300; tick();
    dequeue = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      in_data = 32'h300 + i;
      tick();
      check("wrap_head",  64'(out_data), 64'(32'h300 + i));
      check("wrap_count", 64'(count), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    dequeue = 1'b0;
    check("wrap_end_count", 64'(count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
